// File: rtl/rr_arb_pkg.sv
// ============================================================================
// rr_arb_pkg : shared types and helpers for the round-robin arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  localparam int MAX_N = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Index width: at least one bit so N=1 still has a legal gnt_id port.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_pick.sv
// ============================================================================
// rr_arb_pick : combinational rotating-priority picker (search from ptr_i,
//               wrapping modulo N, skipping bits set in excl_i)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idw(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic [N-1:0]   excl_i,
  output logic [N-1:0]   onehot_o,
  output logic [IDW-1:0] idx_o,
  output logic           found_o
);

  logic [N-1:0] w_cand;

  assign w_cand = req_i & ~excl_i;

  always_comb begin
    int j;
    j        = 0;
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found_o && w_cand[j]) begin
        found_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IDW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : N-way round-robin arbiter with grant ownership; optional
//              hold timeout enabled by macro RR_ARB_TIMEOUT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDW     = idw(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy
);

  localparam logic [IDW-1:0] c_LAST = IDW'(N - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [N-1:0]   w_pick;
  logic [IDW-1:0] w_idx;
  logic           w_found;
  logic           w_owner_req;
  logic           w_timeout;
  logic           w_arbitrate;

  // The current owner is always excluded, so a release or forced rotation
  // hands over to someone else on the same edge.
  rr_arb_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .excl_i   (gnt_q),
    .onehot_o (w_pick),
    .idx_o    (w_idx),
    .found_o  (w_found)
  );

  assign w_owner_req = req[gnt_id_q];
  assign w_arbitrate = (state_q == IDLE) || !w_owner_req || w_timeout;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] c_MAX_HOLD = HW'(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;

  assign w_timeout = (state_q == OWN) && (hold_q == c_MAX_HOLD) && (|(req & ~gnt_q));

  always_comb begin
    hold_d = '0;
    if (w_arbitrate) begin
      if (w_found) hold_d = HW'(1);
    end else begin
      hold_d = (hold_q == c_MAX_HOLD) ? hold_q : hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    if (w_arbitrate) begin
      if (w_found) begin
        state_d  = OWN;
        gnt_d    = w_pick;
        gnt_id_d = w_idx;
        ptr_d    = (w_idx == c_LAST) ? '0 : w_idx + IDW'(1);
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = |gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
// tb_rr_arbiter : self-checking bench for rr_arbiter (N=4 and N=3 instances)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rr_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [2:0] req3;
  logic [2:0] gnt3;
  logic [1:0] gnt_id3;
  logic       busy3;

  int vectors;
  int miscompares;

  rr_arbiter #(.N(4), .MAX_HOLD(MH)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  rr_arbiter #(.N(3), .MAX_HOLD(MH)) u_dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req3),
    .gnt    (gnt3),
    .gnt_id (gnt_id3),
    .busy   (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  // Reference model: owner index (-1 = none), next-priority pointer, hold count.
  int m_owner, m_ptr, m_hold;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    bit keep;
    int w, i;
    keep = 1'b0;
    if (m_owner >= 0 && r[m_owner]) begin
      keep = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
      if (m_hold == MH && (r & ~(4'b1 << m_owner)) != 4'b0) keep = 1'b0;
`endif
    end
    if (keep) begin
      if (m_hold < MH) m_hold++;
    end else begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (w < 0 && i != m_owner && r[i]) w = i;
      end
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % 4;
        m_hold  = 1;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
  endfunction

  function automatic logic [1:0] m_id();
    return (m_owner >= 0) ? 2'(m_owner) : 2'd0;
  endfunction

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei);
    vectors++;
    if (gnt !== eg || gnt_id !== ei || busy !== (|eg)) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
               name, gnt, gnt_id, busy, eg, ei, |eg);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] eg, input logic [1:0] ei);
    vectors++;
    if (gnt3 !== eg || gnt_id3 !== ei || busy3 !== (|eg)) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
               name, gnt3, gnt_id3, busy3, eg, ei, |eg);
    end
  endtask

  // Apply r for one edge, advance the model, compare #1 after the edge.
  task automatic cycle(input logic [3:0] r, input string name);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check(name, m_gnt(), m_id());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    req3  = '0;
    #2;
    check("reset", 4'b0, 2'd0);
    check3("reset3", 3'b0, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[14];
  logic [3:0] r, pg;
  int wt[4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req   = '0;
    req3  = '0;
    model_reset();

    tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
    tbl[1]  = '{4'b1111, 4'b0001, 2'd0};
    tbl[2]  = '{4'b1110, 4'b0010, 2'd1};
    tbl[3]  = '{4'b1111, 4'b0010, 2'd1};
    tbl[4]  = '{4'b1101, 4'b0100, 2'd2};
    tbl[5]  = '{4'b1111, 4'b0100, 2'd2};
    tbl[6]  = '{4'b1011, 4'b1000, 2'd3};
    tbl[7]  = '{4'b1111, 4'b1000, 2'd3};
    tbl[8]  = '{4'b0111, 4'b0001, 2'd0};
    tbl[9]  = '{4'b0000, 4'b0000, 2'd0};
    tbl[10] = '{4'b0100, 4'b0100, 2'd2};
    tbl[11] = '{4'b0000, 4'b0000, 2'd0};
    tbl[12] = '{4'b0010, 4'b0010, 2'd1};
    tbl[13] = '{4'b0000, 4'b0000, 2'd0};

    do_reset();
    for (int v = 0; v < 14; v++) begin
      req = tbl[v].r;
      @(posedge clk);
      model_step(tbl[v].r);
      #1;
      check($sformatf("table[%0d]", v), tbl[v].g, tbl[v].id);
    end

    // Owner 1 holds while requester 3 waits.
    cycle(4'b0010, "hold_grant");
    for (int c = 0; c < 100; c++) cycle(4'b1010, "hold_model");
`ifndef RR_ARB_TIMEOUT_EN
    check("hold_100", 4'b0010, 2'd1);
`endif
    cycle(4'b1000, "hold_release");
`ifndef RR_ARB_TIMEOUT_EN
    check("hold_handover", 4'b1000, 2'd3);
`endif

    // Asynchronous reset while requester 3 owns the grant.
    do_reset();
    cycle(4'b1000, "pre_async");
    check("pre_async_c", 4'b1000, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 4'b0000, 2'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b1010, "post_async");
    check("post_async_c", 4'b0010, 2'd1);

`ifdef RR_ARB_TIMEOUT_EN
    do_reset();
    for (int c = 0; c < MH; c++) cycle(4'b0101, "to_hold");
    check("to_before", 4'b0001, 2'd0);
    cycle(4'b0101, "to_switch");
    check("to_after", 4'b0100, 2'd2);
    do_reset();
    for (int c = 0; c < 3 * MH; c++) cycle(4'b0001, "to_alone");
    check("to_alone_c", 4'b0001, 2'd0);
`endif

    // N=3 wrap-around.
    do_reset();
    req3 = 3'b100;
    @(posedge clk);
    #1;
    check3("n3_first", 3'b100, 2'd2);
    req3 = 3'b011;
    @(posedge clk);
    #1;
    check3("n3_wrap", 3'b001, 2'd0);
    req3 = 3'b000;

    // Random traffic against the model plus a starvation bound.
    do_reset();
    r  = '0;
    pg = '0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      cycle(r, "random");
      vectors++;
      if ($countones(gnt) > 1) begin
        miscompares++;
        $display("FAIL onehot: got gnt=%b, expected at most one bit set", gnt);
      end
      for (int i = 0; i < 4; i++) begin
        if (!r[i] || gnt[i]) wt[i] = 0;
        else if (gnt != 4'b0 && gnt != pg) wt[i]++;
        if (wt[i] > 3) begin
          miscompares++;
          $display("FAIL starve[%0d]: got %0d tenures waited, expected at most 3", i, wt[i]);
          wt[i] = 0;
        end
      end
      pg = gnt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-way round-robin arbiter with registered one-hot grants and grant ownership. A requester keeps its grant for as long as it holds its request. The grant then rotates fairly, and an optional hold-timeout forces rotation. Sits in front of any shared resource (bus port, memory, UART TX) where several masters contend, replacing fixed-priority selection.

## Interface
- `N`, default 4: number of requesters, 1..32.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before forced rotation. Used only when the timeout feature is compiled in; must be ≥1.
- `clk`, input, 1 bit: single clock, rising-edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset. Assertion is asynchronous; deassertion is sampled on `clk`.
- `req`, input, N bits: request vector; bit i is requester i.
- `gnt`, output, N bits: registered one-hot grant, or all zero.
- `gnt_id`, output, IDW = max(1, clog2(N)) bits: binary index of the granted requester; 0 when `gnt` is zero.
- `busy`, output, 1 bit: high while any grant is active (equals OR of `gnt`).

## Operation
- States: IDLE (no owner) and OWN (one owner; `gnt` holds its bit).
- Priority pointer `ptr` (IDW bits) names the requester with highest priority next. The search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, wrapping modulo N (N need not be a power of two).
- IDLE: if `req` is nonzero, pick the first set bit in search order, go to OWN, set `gnt`/`gnt_id`, and set `ptr` to winner+1 mod N. Otherwise stay in IDLE with outputs zero.
- OWN, owner's `req` high (and no timeout): hold the grant and leave `ptr` unchanged. Other requests wait.
- OWN, owner's `req` low: release. In the same edge, arbitrate among the remaining requests (owner excluded) using `ptr`.
  - A winner gives zero-bubble handover: the new grant appears directly, `ptr` moves to winner+1.
  - No winner: go to IDLE.
- Requests from non-owners may change freely. A request dropped before it is granted is simply not considered.
- Never more than one `gnt` bit is set. `gnt` never asserts for a requester whose `req` was low on the deciding edge.
- With N=1: `gnt[0]` follows `req[0]` one cycle late and `ptr` stays 0.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `busy`=0, state IDLE, `ptr`=0 (so requester 0 wins first after reset), hold counter 0.
- Latency: `req` sampled at edge t, `gnt` visible after edge t (one-cycle registered).
- Release latency: owner drops `req` before edge t, and its `gnt` clears or hands over at edge t.
- Grant and release on the same edge: release takes precedence; the owner is excluded from that edge's arbitration.
- Reset mid-grant: all outputs clear immediately (asynchronously) and arbitration restarts from `ptr`=0.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter (clog2(MAX_HOLD+1) bits) counts owner cycles.
  - It resets to 1 on each new grant and saturates at MAX_HOLD.
  - When the counter equals MAX_HOLD and any other requester is pending, the owner is forcibly released on the next edge. Arbitration then runs exactly as on a voluntary release, with the owner excluded.
  - With no other request pending, the owner keeps the grant and the counter stays saturated.
- Undefined: no counter; an owner keeps the grant indefinitely while `req` is held. `MAX_HOLD` is ignored.

## Structure
- Package `rr_arb_pkg`: state enum (IDLE, OWN), IDW width function, and a constant for the maximum N.
- Sub-module `rr_arb_pick`: purely combinational masked priority picker.
  - Inputs: request vector, pointer, exclude mask.
  - Outputs: one-hot winner, index, and found flag.
  - Instantiated once in `rr_arbiter`. All state and registers live in `rr_arbiter`.

## Test plan
- Reset, then `req`=4'b1111 held: `gnt`=0001 after the first edge. Drop each owner's req after 2 cycles and re-raise it: grants go 0001→0010→0100→1000→0001 with no idle cycle between them.
- `req`=4'b0100 alone, then `req`=0: `gnt`=0100 and `gnt_id`=2 one cycle later. After release, `gnt`=0 and `busy`=0, and the next single request 4'b0010 is granted in one cycle.
- Owner 1 holds its req while `req[3]` rises (timeout compiled out): `gnt` stays 0010 for 100 cycles. On owner release, `gnt`=1000 on the next edge.
- With `RR_ARB_TIMEOUT_EN` and MAX_HOLD=4:
  - Owner 0 holds its req and `req[2]` is pending: `gnt` switches to 0100 after exactly 4 grant cycles.
  - With no other request pending: `gnt` stays 0001.
- N=3, wrap-around: owner 2 releases while `req`=3'b011, so `gnt`=001.
- Assert `rst_n` low while `gnt`=1000: `gnt`, `gnt_id` and `busy` clear asynchronously. After reset with `req`=1010, `gnt`=0010.
- Random `req` for 10k cycles: at most one grant bit is set at any time, and every continuously pending requester is granted within N-1 grant tenures.
